// File: rtl/finger_scanner.sv
// Pixel-stream front end: tracks x/y over a camera frame and emits one finger vote per ROI pixel.
// Optional FINGER_SCANNER_MAJORITY_EN: vote bit is a 3-tap in-row majority instead of the raw compare.
module finger_scanner #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int ROW_START  = 200,
  parameter int ROW_END    = 279,
  parameter int NUM_KEYS   = 39
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_start,
  input  logic        pix_valid,
  input  logic [7:0]  pix_luma,
  input  logic [7:0]  threshold,
  output logic [31:0] addr,
  output logic [1:0]  q,
  output logic        scan_active,
  output logic        frame_done
);

  typedef enum logic [1:0] {S_IDLE, S_SKIP, S_SCAN, S_DONE} state_t;

  localparam logic [15:0] X_LAST     = 16'(IMG_WIDTH - 1);
  localparam logic [15:0] Y_SAT      = 16'(IMG_HEIGHT);
  localparam logic [15:0] VOTE_X_MAX = 16'((NUM_KEYS + 1) * 8 - 1);
  localparam logic [15:0] ROI_LAST   = 16'(ROW_END);
  localparam logic [15:0] SKIP_LAST  = (ROW_START == 0) ? 16'd0 : 16'(ROW_START - 1);

  state_t      state, state_cur, state_next;
  logic [15:0] x, y, x_cur, y_cur, x_next, y_next;
  logic        accept, finger, vote, vote_bit, done_next;
  logic [31:0] addr_next;
  logic [1:0]  q_next;
`ifdef FINGER_SCANNER_MAJORITY_EN
  logic [1:0]  hist, hist_cur, hist_next;
`endif

  always_comb begin
    state_cur = state;
    x_cur     = x;
    y_cur     = y;
    // A frame_start pixel is processed as (0,0) under the new frame's state.
    if (frame_start) begin
      state_cur = (ROW_START == 0) ? S_SCAN : S_SKIP;
      x_cur     = 16'd0;
      y_cur     = 16'd0;
    end

    accept     = pix_valid && (state_cur == S_SKIP || state_cur == S_SCAN);
    finger     = pix_luma > threshold;
    state_next = state_cur;
    x_next     = x_cur;
    y_next     = y_cur;
    done_next  = 1'b0;

    if (accept) begin
      if (x_cur == X_LAST) begin
        x_next = 16'd0;
        if (y_cur != Y_SAT) y_next = y_cur + 16'd1;
        if (state_cur == S_SKIP && y_cur == SKIP_LAST) state_next = S_SCAN;
        if (state_cur == S_SCAN && y_cur == ROI_LAST) begin
          state_next = S_DONE;
          done_next  = 1'b1;
        end
      end else begin
        x_next = x_cur + 16'd1;
      end
    end

    vote = accept && (state_cur == S_SCAN) && (x_cur <= VOTE_X_MAX);

`ifdef FINGER_SCANNER_MAJORITY_EN
    // hist[0] is the previous pixel, hist[1] the one before; both forgotten at row start.
    hist_cur  = (frame_start || x_cur == 16'd0) ? 2'b00 : hist;
    vote_bit  = (finger & hist_cur[0]) | (finger & hist_cur[1]) | (hist_cur[0] & hist_cur[1]);
    hist_next = accept ? {hist_cur[0], finger} : hist_cur;
`else
    vote_bit  = finger;
`endif

    q_next    = vote ? {1'b1, vote_bit} : 2'b00;
    addr_next = vote ? {y_cur, x_cur} : addr;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= S_IDLE;
      x           <= 16'd0;
      y           <= 16'd0;
      addr        <= 32'd0;
      q           <= 2'b00;
      scan_active <= 1'b0;
      frame_done  <= 1'b0;
`ifdef FINGER_SCANNER_MAJORITY_EN
      hist        <= 2'b00;
`endif
    end else begin
      state       <= state_next;
      x           <= x_next;
      y           <= y_next;
      addr        <= addr_next;
      q           <= q_next;
      scan_active <= (state_next == S_SCAN);
      frame_done  <= done_next;
`ifdef FINGER_SCANNER_MAJORITY_EN
      hist        <= hist_next;
`endif
    end
  end

endmodule

// File: tb/tb_finger_scanner.sv
// Scoreboard bench for finger_scanner on a reduced frame geometry; a frame-level model
// pushes expected votes and per-cycle status, a negedge monitor pops and compares.
module tb_finger_scanner;

  localparam int W  = 80;
  localparam int H  = 16;
  localparam int RS = 3;
  localparam int RE = 6;
  localparam int NK = 5;
  localparam int XV = (NK + 1) * 8 - 1;

  logic        clk = 1'b0;
  logic        rst, frame_start, pix_valid;
  logic [7:0]  pix_luma, threshold;
  logic [31:0] addr;
  logic [1:0]  q;
  logic        scan_active, frame_done;

  always #5 clk = ~clk;

  finger_scanner #(
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H),
    .ROW_START (RS),
    .ROW_END   (RE),
    .NUM_KEYS  (NK)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .frame_start(frame_start),
    .pix_valid  (pix_valid),
    .pix_luma   (pix_luma),
    .threshold  (threshold),
    .addr       (addr),
    .q          (q),
    .scan_active(scan_active),
    .frame_done (frame_done)
  );

  typedef struct {
    int          tag;
    logic [31:0] addr;
    logic [1:0]  q;
  } vote_t;

  typedef struct {
    int tag;
    bit scan;
    bit done;
    bit rst_rec;
  } ctl_t;

  vote_t vote_q[$];
  ctl_t  ctl_q[$];

  int edge_count = 0;
  int compared   = 0;
  int mismatched = 0;
  bit finish_req = 1'b0;

  // Frame model: position within the frame and whether a frame is still being walked.
  bit m_active = 1'b0;
  int m_x = 0;
  int m_y = 0;
  bit row_bits [W];

  always @(posedge clk) edge_count <= edge_count + 1;

  // One cycle of stimulus; the model predicts what appears after the coming posedge.
  task automatic applyStimulus(input bit rst_val, input bit fs, input bit pv,
                               input logic [7:0] luma, input logic [7:0] thr);
    int tag;
    bit fb;
    bit done_e;
    int cnt;
    rst         = rst_val;
    frame_start = fs;
    pix_valid   = pv;
    pix_luma    = luma;
    threshold   = thr;
    tag         = edge_count + 1;
    if (!rst_val) begin
      m_active = 1'b0;
      m_x      = 0;
      m_y      = 0;
      ctl_q.push_back('{tag, 1'b0, 1'b0, 1'b1});
    end else begin
      if (fs) begin
        m_active = 1'b1;
        m_x      = 0;
        m_y      = 0;
      end
      done_e = 1'b0;
      if (pv && m_active) begin
        fb = (luma > thr);
        row_bits[m_x] = fb;
`ifdef FINGER_SCANNER_MAJORITY_EN
        cnt = int'(fb);
        if (m_x >= 1) cnt += int'(row_bits[m_x - 1]);
        if (m_x >= 2) cnt += int'(row_bits[m_x - 2]);
        fb = (cnt >= 2);
`else
        cnt = 0;
`endif
        if (m_y >= RS && m_y <= RE && m_x <= XV)
          vote_q.push_back('{tag, {16'(m_y), 16'(m_x)}, {1'b1, fb}});
        if (m_x == W - 1 && m_y == RE) begin
          done_e   = 1'b1;
          m_active = 1'b0;
        end
        m_x++;
        if (m_x == W) begin
          m_x = 0;
          if (m_y < H) m_y++;
        end
      end
      ctl_q.push_back('{tag, m_active && m_y >= RS && m_y <= RE, done_e, 1'b0});
    end
    @(negedge clk);
  endtask

  // mode 0: luma 255, mode 1: luma 0, mode 2: random, mode 3: 255,0,255,255 repeating.
  task automatic runFrame(input int mode, input int pct_valid, input int ncycles, input bit with_fs);
    bit          fs, pv;
    logic [7:0]  luma, thr;
    int          px;
    for (int i = 0; i < ncycles; i++) begin
      fs  = with_fs && (i == 0);
      pv  = ($urandom_range(99) < pct_valid);
      px  = fs ? 0 : m_x;
      thr = 8'd128;
      case (mode)
        0: luma = 8'd255;
        1: luma = 8'd0;
        3: luma = (px % 4 == 1) ? 8'd0 : 8'd255;
        default: begin
          thr  = 8'($urandom_range(255));
          luma = ($urandom_range(7) == 0) ? thr : 8'($urandom_range(255));
        end
      endcase
      applyStimulus(1'b1, fs, pv, luma, thr);
    end
  endtask

  task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: actual 0x%0h, required 0x%0h (edge %0d)", nm, act, exp, edge_count);
    end
  endtask

  // Monitor: votes are matched in order against the scoreboard; status is checked per cycle.
  always @(negedge clk) begin
    vote_t v;
    ctl_t  c;
    if (q[1] === 1'b1) begin
      if (vote_q.size() == 0) begin
        checkOutput("spurious_vote", 32'(q), 32'd0);
      end else begin
        v = vote_q.pop_front();
        checkOutput("vote_cycle", 32'(edge_count), 32'(v.tag));
        checkOutput("vote_addr", addr, v.addr);
        checkOutput("vote_q", 32'(q), 32'(v.q));
      end
    end else if (vote_q.size() > 0 && vote_q[0].tag <= edge_count) begin
      v = vote_q.pop_front();
      checkOutput("missing_vote", 32'(q), 32'(v.q));
    end

    while (ctl_q.size() > 0 && ctl_q[0].tag < edge_count) c = ctl_q.pop_front();
    if (ctl_q.size() > 0 && ctl_q[0].tag == edge_count) begin
      c = ctl_q.pop_front();
      checkOutput("scan_active", 32'(scan_active), 32'(c.scan));
      checkOutput("frame_done", 32'(frame_done), 32'(c.done));
      if (q[1] !== 1'b1) checkOutput("idle_q", 32'(q), 32'd0);
      if (c.rst_rec) checkOutput("reset_addr", addr, 32'd0);
    end

    if (finish_req) begin
      checkOutput("votes_outstanding", 32'(vote_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
    end
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst         = 1'b0;
    frame_start = 1'b0;
    pix_valid   = 1'b0;
    pix_luma    = 8'd0;
    threshold   = 8'd128;

    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b1, 8'd255, 8'd128);
    $display("[TB] idle pixels before any frame_start");
    runFrame(0, 100, 10, 1'b0);

    $display("[TB] full frame, luma 255 then luma 0");
    runFrame(0, 100, W * H + 5, 1'b1);
    runFrame(1, 100, W * H + 5, 1'b1);

    $display("[TB] ROI luma pattern 255,0,255,255");
    runFrame(3, 100, W * H + 2, 1'b1);

    $display("[TB] abort inside ROI then fresh frame");
    runFrame(0, 100, 5 * W + 10, 1'b1);
    runFrame(0, 100, W * H + 5, 1'b1);

    $display("[TB] reset mid-scan");
    runFrame(2, 100, 4 * W + 20, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'd255, 8'd0);
    runFrame(0, 100, 50, 1'b0);
    runFrame(2, 80, 2000, 1'b1);

    $display("[TB] random frames with gaps");
    for (int f = 0; f < 3; f++) runFrame(2, 70, (W * H * 3) / 2 + f * 37, 1'b1);

    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, 8'd0, 8'd0);
    finish_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
  end

endmodule
